// File: rtl/sc_regshifter_pkg.sv
// Shared encodings for the SC_RegSHIFTER controller and its datapath integration.
// Holds the FSM state type, the datapath selection codes and the direction-to-code mapping.
package sc_regshifter_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_WAIT  = 3'd2,
    ST_SHIFT = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  typedef enum logic [1:0] {
    SEL_HOLD = 2'b00,
    SEL_LOAD = 2'b01,
    SEL_SHL  = 2'b10,
    SEL_SHR  = 2'b11
  } shiftsel_t;

  function automatic shiftsel_t shift_code(input logic dir);
    return dir ? SEL_SHR : SEL_SHL;
  endfunction

endpackage

// File: rtl/sc_tick_timer.sv
// Loadable down-counter that paces the gap between shift commands.
// Stops at zero instead of wrapping; clear has priority over load and decrement.
module sc_tick_timer #(
  parameter int DATA_W = 16
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_clr,
  input  logic              i_load,
  input  logic [DATA_W-1:0] i_load_val,
  input  logic              i_dec,
  output logic              o_zero
);

  localparam logic [DATA_W-1:0] ONE = DATA_W'(1);

  logic [DATA_W-1:0] r_count;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_count <= '0;
    end else if (i_clr) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (i_dec && (r_count != '0)) begin
      r_count <= r_count - ONE;
    end
  end

  assign o_zero = (r_count == '0);

endmodule

// File: rtl/sc_regshifter_ctrl.sv
// Sequencer for the SC_RegSHIFTER datapath: load a seed, then issue N spaced shifts.
// All outputs are registered and change together with the state they belong to.
module sc_regshifter_ctrl
  import sc_regshifter_pkg::*;
#(
  parameter int RegSHIFTERCTRL_DATAWIDTH  = 8,
  parameter int RegSHIFTERCTRL_COUNTWIDTH = 4,
  parameter int RegSHIFTERCTRL_DIVWIDTH   = 16
) (
  input  logic                                 SC_RegSHIFTERCTRL_CLOCK_50,
  input  logic                                 SC_RegSHIFTERCTRL_RESET_InLow,
  input  logic                                 SC_RegSHIFTERCTRL_start_InHigh,
  input  logic                                 SC_RegSHIFTERCTRL_abort_InHigh,
  input  logic                                 SC_RegSHIFTERCTRL_dir_In,
  input  logic [RegSHIFTERCTRL_COUNTWIDTH-1:0] SC_RegSHIFTERCTRL_count_In,
  input  logic [RegSHIFTERCTRL_DIVWIDTH-1:0]   SC_RegSHIFTERCTRL_period_In,
  input  logic [RegSHIFTERCTRL_DATAWIDTH-1:0]  SC_RegSHIFTERCTRL_seed_In,
  output logic [1:0]                           SC_RegSHIFTERCTRL_shiftselection_Out,
  output logic [RegSHIFTERCTRL_DATAWIDTH-1:0]  SC_RegSHIFTERCTRL_data_OutBUS,
  output logic                                 SC_RegSHIFTERCTRL_busy_Out,
  output logic                                 SC_RegSHIFTERCTRL_done_OutHigh,
  output logic [RegSHIFTERCTRL_COUNTWIDTH-1:0] SC_RegSHIFTERCTRL_remaining_Out
);

  localparam int CW = RegSHIFTERCTRL_COUNTWIDTH;
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  state_t                                r_state;
  shiftsel_t                             r_sel;
  logic [RegSHIFTERCTRL_DATAWIDTH-1:0]   r_data;
  logic                                  r_busy;
  logic                                  r_done;
  logic [CW-1:0]                         r_remaining;
  logic                                  r_dir;
  logic [RegSHIFTERCTRL_DIVWIDTH-1:0]    r_period;

  logic w_abort_now;
  logic w_timer_load;
  logic w_timer_dec;
  logic w_timer_zero;

  assign w_abort_now  = SC_RegSHIFTERCTRL_abort_InHigh && (r_state != ST_IDLE);
  // Reload the gap timer whenever the FSM is about to enter WAIT.
  assign w_timer_load = !w_abort_now && (r_remaining != '0) &&
                        ((r_state == ST_LOAD) || (r_state == ST_SHIFT));
  assign w_timer_dec  = (r_state == ST_WAIT) && !w_timer_zero;

  sc_tick_timer #(
    .DATA_W (RegSHIFTERCTRL_DIVWIDTH)
  ) u_timer (
    .i_clk      (SC_RegSHIFTERCTRL_CLOCK_50),
    .i_rst_n    (SC_RegSHIFTERCTRL_RESET_InLow),
    .i_clr      (w_abort_now),
    .i_load     (w_timer_load),
    .i_load_val (r_period),
    .i_dec      (w_timer_dec),
    .o_zero     (w_timer_zero)
  );

  always_ff @(posedge SC_RegSHIFTERCTRL_CLOCK_50 or negedge SC_RegSHIFTERCTRL_RESET_InLow) begin
    if (!SC_RegSHIFTERCTRL_RESET_InLow) begin
      r_state     <= ST_IDLE;
      r_sel       <= SEL_HOLD;
      r_data      <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_remaining <= '0;
      r_dir       <= 1'b0;
      r_period    <= '0;
    end else begin
      r_done <= 1'b0;
      if (w_abort_now) begin
        r_state     <= ST_IDLE;
        r_sel       <= SEL_HOLD;
        r_data      <= '0;
        r_busy      <= 1'b0;
        r_remaining <= '0;
      end else begin
        case (r_state)
          ST_IDLE: begin
            if (SC_RegSHIFTERCTRL_start_InHigh && !SC_RegSHIFTERCTRL_abort_InHigh) begin
              r_state     <= ST_LOAD;
              r_sel       <= SEL_LOAD;
              r_data      <= SC_RegSHIFTERCTRL_seed_In;
              r_busy      <= 1'b1;
              r_remaining <= SC_RegSHIFTERCTRL_count_In;
              r_dir       <= SC_RegSHIFTERCTRL_dir_In;
              r_period    <= SC_RegSHIFTERCTRL_period_In;
            end
          end
          ST_LOAD: begin
            r_sel <= SEL_HOLD;
            if (r_remaining == '0) begin
              r_state <= ST_DONE;
              r_done  <= 1'b1;
            end else begin
              r_state <= ST_WAIT;
            end
          end
          ST_WAIT: begin
            // Remaining is decremented on entry so it reads "still to issue" during SHIFT.
            if (w_timer_zero) begin
              r_state <= ST_SHIFT;
              r_sel   <= shift_code(r_dir);
              if (r_remaining != '0) r_remaining <= r_remaining - CNT_ONE;
            end
          end
          ST_SHIFT: begin
            r_sel <= SEL_HOLD;
            if (r_remaining == '0) begin
              r_state <= ST_DONE;
              r_done  <= 1'b1;
            end else begin
              r_state <= ST_WAIT;
            end
          end
          ST_DONE: begin
            r_state <= ST_IDLE;
            r_sel   <= SEL_HOLD;
            r_busy  <= 1'b0;
          end
          default: begin
            r_state <= ST_IDLE;
            r_sel   <= SEL_HOLD;
            r_busy  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign SC_RegSHIFTERCTRL_shiftselection_Out = r_sel;
  assign SC_RegSHIFTERCTRL_data_OutBUS        = r_data;
  assign SC_RegSHIFTERCTRL_busy_Out           = r_busy;
  assign SC_RegSHIFTERCTRL_done_OutHigh       = r_done;
  assign SC_RegSHIFTERCTRL_remaining_Out      = r_remaining;

endmodule

// File: tb/tb_sc_regshifter_ctrl.sv
// Self-checking bench for sc_regshifter_ctrl against a cycle-index timing model.
// Expected outputs are derived from the shift schedule formula, not from FSM states.
module tb_sc_regshifter_ctrl;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        abort;
  logic        dir;
  logic [3:0]  count;
  logic [15:0] period;
  logic [7:0]  seed;
  logic [1:0]  sel;
  logic [7:0]  data;
  logic        busy;
  logic        done;
  logic [3:0]  rem;

  int checks   = 0;
  int failures = 0;

  sc_regshifter_ctrl #(
    .RegSHIFTERCTRL_DATAWIDTH  (8),
    .RegSHIFTERCTRL_COUNTWIDTH (4),
    .RegSHIFTERCTRL_DIVWIDTH   (16)
  ) dut (
    .SC_RegSHIFTERCTRL_CLOCK_50           (clk),
    .SC_RegSHIFTERCTRL_RESET_InLow        (rst_n),
    .SC_RegSHIFTERCTRL_start_InHigh       (start),
    .SC_RegSHIFTERCTRL_abort_InHigh       (abort),
    .SC_RegSHIFTERCTRL_dir_In             (dir),
    .SC_RegSHIFTERCTRL_count_In           (count),
    .SC_RegSHIFTERCTRL_period_In          (period),
    .SC_RegSHIFTERCTRL_seed_In            (seed),
    .SC_RegSHIFTERCTRL_shiftselection_Out (sel),
    .SC_RegSHIFTERCTRL_data_OutBUS        (data),
    .SC_RegSHIFTERCTRL_busy_Out           (busy),
    .SC_RegSHIFTERCTRL_done_OutHigh       (done),
    .SC_RegSHIFTERCTRL_remaining_Out      (rem)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0] sel;
    logic [7:0] data;
    logic       busy;
    logic       done;
    logic [3:0] rem;
  } exp_t;

  // Expected outputs in cycle c (LOAD = cycle 1): shift i lands in 1+i*(P+2), done in 2+N*(P+2).
  function automatic exp_t model(input int n, input int p, input logic d, input logic [7:0] s,
                                 input int c, input int abort_at);
    exp_t e;
    int   dc;
    int   issued;
    dc = 2 + n * (p + 2);
    e  = '0;
    if (abort_at > 0 && c > abort_at) return e;
    if (c > dc) begin
      e.data = s;
      return e;
    end
    e.data = s;
    e.busy = 1'b1;
    e.done = (c == dc);
    if (c == 1) e.sel = 2'b01;
    else if (c < dc && ((c - 1) % (p + 2)) == 0) e.sel = d ? 2'b11 : 2'b10;
    issued = (c <= 1) ? 0 : (c - 1) / (p + 2);
    if (issued > n) issued = n;
    e.rem = 4'(n - issued);
    return e;
  endfunction

  // Entered and left at a falling edge; start is raised at entry and sampled by the next rising edge.
  task automatic run_sequence(input int n, input int p, input logic d, input logic [7:0] s,
                              input int abort_at, input int stray_at, input string tag);
    int   last;
    exp_t e;
    last   = (abort_at > 0) ? abort_at + 1 : 2 + n * (p + 2) + 1;
    start  = 1'b1;
    dir    = d;
    count  = 4'(n);
    period = 16'(p);
    seed   = s;
    for (int c = 1; c <= last; c++) begin
      @(negedge clk);
      if (c == 1) begin
        start  = 1'b0;
        dir    = 1'($urandom);
        count  = 4'($urandom);
        period = 16'($urandom_range(40, 0));
        seed   = 8'($urandom);
      end
      e = model(n, p, d, s, c, abort_at);
      checks += 5;
      if (sel !== e.sel) begin
        failures++;
        $display("FAIL %s sel cycle=%0d got=%b exp=%b", tag, c, sel, e.sel);
      end
      if (data !== e.data) begin
        failures++;
        $display("FAIL %s data cycle=%0d got=%h exp=%h", tag, c, data, e.data);
      end
      if (busy !== e.busy) begin
        failures++;
        $display("FAIL %s busy cycle=%0d got=%b exp=%b", tag, c, busy, e.busy);
      end
      if (done !== e.done) begin
        failures++;
        $display("FAIL %s done cycle=%0d got=%b exp=%b", tag, c, done, e.done);
      end
      if (rem !== e.rem) begin
        failures++;
        $display("FAIL %s remaining cycle=%0d got=%0d exp=%0d", tag, c, rem, e.rem);
      end
      if (c == stray_at) start = 1'b1;
      else if (c == stray_at + 1) start = 1'b0;
      if (c == abort_at) abort = 1'b1;
      else if (abort_at > 0 && c == abort_at + 1) abort = 1'b0;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    start = 1'b0;
    abort = 1'b0;
    dir = 1'b0;
    count = '0;
    period = '0;
    seed = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checks++;
      if ({sel, data, busy, done, rem} !== '0) begin
        failures++;
        $display("FAIL reset_idle cycle=%0d got sel=%b data=%h busy=%b done=%b rem=%0d exp all zero",
                 i, sel, data, busy, done, rem);
      end
    end
  endtask

  task automatic test_basic();
    run_sequence(3, 1, 1'b0, 8'hA5, 0, 0, "basic");
  endtask

  task automatic test_zero_count();
    run_sequence(0, 5, 1'b1, 8'h3C, 0, 0, "zero_count");
  endtask

  task automatic test_stray_start();
    run_sequence(2, 0, 1'b1, 8'h5A, 0, 4, "stray_start");
  endtask

  task automatic test_abort();
    run_sequence(4, 3, 1'b0, 8'hC3, 7, 0, "abort");
    run_sequence(2, 2, 1'b1, 8'h81, 0, 0, "after_abort");
  endtask

  task automatic test_abort_idle();
    start = 1'b1;
    abort = 1'b1;
    seed  = 8'hFF;
    count = 4'd3;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (busy !== 1'b0 || sel !== 2'b00) begin
        failures++;
        $display("FAIL abort_idle cycle=%0d got busy=%b sel=%b exp busy=0 sel=00", i, busy, sel);
      end
    end
    start = 1'b0;
    abort = 1'b0;
  endtask

  task automatic test_back_to_back();
    // Start held through DONE must be ignored; the next start at the first IDLE edge is accepted.
    run_sequence(2, 1, 1'b0, 8'h11, 0, 2 + 2 * 3, "b2b_first");
    run_sequence(1, 0, 1'b1, 8'h22, 0, 0, "b2b_second");
  endtask

  task automatic test_random();
    int n, p, ab, st, dc;
    for (int k = 0; k < 20; k++) begin
      n  = int'($urandom_range(15, 0));
      p  = int'($urandom_range(5, 0));
      dc = 2 + n * (p + 2);
      ab = ($urandom_range(3, 0) == 0) ? int'($urandom_range(dc, 1)) : 0;
      st = ($urandom_range(1, 0) == 0) ? int'($urandom_range(dc, 2)) : 0;
      if (ab > 0 && st >= ab) st = 0;
      run_sequence(n, p, 1'($urandom), 8'($urandom), ab, st, "random");
    end
  endtask

  task automatic test_async_reset();
    start  = 1'b1;
    dir    = 1'b0;
    count  = 4'd4;
    period = 16'd3;
    seed   = 8'h96;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (busy !== 1'b1 || data !== 8'h96) begin
      failures++;
      $display("FAIL async_pre got busy=%b data=%h exp busy=1 data=96", busy, data);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({sel, data, busy, done, rem} !== '0) begin
      failures++;
      $display("FAIL async_reset got sel=%b data=%h busy=%b done=%b rem=%0d exp all zero",
               sel, data, busy, done, rem);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      checks++;
      if (done !== 1'b0 || busy !== 1'b0) begin
        failures++;
        $display("FAIL async_after cycle=%0d got done=%b busy=%b exp 0 0", i, done, busy);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_zero_count();
    test_stray_start();
    test_abort();
    test_abort_idle();
    test_back_to_back();
    test_random();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
